// File: rtl/isa_mailbox_pkg.sv
// Shared constants and types for the ISA mailbox responder.
// Register offsets, STATUS/CONTROL bit indices, bus cycle kinds.
package isa_mailbox_pkg;

   localparam logic [1:0] OFF_DATA    = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_CONTROL = 2'd2;
   localparam logic [1:0] OFF_RXCOUNT = 2'd3;

   localparam int ST_RX_NE = 0;
   localparam int ST_TX_NF = 1;
   localparam int ST_ERR   = 2;
   localparam int ST_IRQ   = 3;
   localparam int ST_TC    = 4;

   localparam int CT_RX_IRQ  = 0;
   localparam int CT_TX_IRQ  = 1;
   localparam int CT_DMA_EN  = 2;
   localparam int CT_DMA_DIR = 3;
   localparam int CT_TC_IRQ  = 4;

   typedef enum logic [2:0] {
      CYC_NONE,
      CYC_IO_RD,
      CYC_IO_WR,
      CYC_DMA_RD,
      CYC_DMA_WR
   } cyc_t;

endpackage

// File: rtl/isa_mailbox_fifo.sv
// Synchronous show-ahead FIFO used for the RX and TX byte paths.
// Push is ignored when full, pop is ignored when empty.
module isa_mailbox_fifo #(
   parameter int DEPTH = 16,
   parameter int W = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + (AW+1)'(1);
         else if (do_pop && !do_push)
            count <= count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/isa_mailbox_responder.sv
// ISA I/O + DMA slave mailbox with RX/TX byte FIFOs.
// DMA cycles, DREQ and TC handling exist only with ISA_MAILBOX_DMA_EN.
module isa_mailbox_responder
   import isa_mailbox_pkg::*;
#(
   parameter logic [9:0] BASE_ADDR = 10'h2E0,
   parameter int FIFO_DEPTH = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [19:0] address,
   input  logic [7:0]  data_bus,
   input  logic        io_read_n,
   input  logic        io_write_n,
   input  logic        address_enable_n,
   input  logic        dma_acknowledge_n,
   input  logic        terminal_count_n,
   output logic [7:0]  data_bus_out,
   output logic        data_bus_out_enable,
   output logic        io_channel_ready,
   output logic        interrupt_request,
   output logic        dma_request,
   input  logic [7:0]  rx_in_data,
   input  logic        rx_in_valid,
   output logic        rx_in_ready,
   output logic [7:0]  tx_out_data,
   output logic        tx_out_valid,
   input  logic        tx_out_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int WW = $clog2(WAIT_CYCLES + 2);

`ifdef ISA_MAILBOX_DMA_EN
   localparam logic [4:0] CTRL_MASK = 5'h1F;
`else
   localparam logic [4:0] CTRL_MASK = 5'h03;
`endif

   logic          prev_low;
   logic          in_cycle;
   cyc_t          cyc;
   logic [1:0]    cyc_off;
   logic          rd_empty_q;
   logic [7:0]    wdata_q;
   logic [WW-1:0] wait_cnt;
   logic [4:0]    ctrl;
   logic          err;
   logic          tc_seen;

   logic          rx_full, rx_empty, tx_full, tx_empty;
   logic [7:0]    rx_head;
   logic [CW-1:0] rx_count, tx_count;

   logic rd_low, wr_low, strobe_low;
   logic hit, dma_cyc, start, end_cyc;
   logic is_rd_cyc, is_dma_cyc;
   logic rx_pop, tx_push;
   logic [1:0] rd_off;
   logic [7:0] rd_val, status_val;
   cyc_t start_type;

   assign rd_low     = ~io_read_n;
   assign wr_low     = ~io_write_n;
   assign strobe_low = rd_low | wr_low;
   assign hit        = (address[9:2] == BASE_ADDR[9:2])
                     & ~address_enable_n;

`ifdef ISA_MAILBOX_DMA_EN
   assign dma_cyc = ~dma_acknowledge_n & address_enable_n
                  & ctrl[CT_DMA_EN];
`else
   assign dma_cyc = 1'b0;
`endif

   // A start needs exactly one strobe falling and a qualifying cycle.
   assign start = ~in_cycle & strobe_low & ~prev_low
                & (rd_low ^ wr_low) & (hit | dma_cyc);

   assign start_type = dma_cyc ? (rd_low ? CYC_DMA_RD : CYC_DMA_WR)
                               : (rd_low ? CYC_IO_RD : CYC_IO_WR);
   assign rd_off     = dma_cyc ? OFF_DATA : address[1:0];

   assign is_rd_cyc  = (cyc == CYC_IO_RD) | (cyc == CYC_DMA_RD);
   assign is_dma_cyc = (cyc == CYC_DMA_RD) | (cyc == CYC_DMA_WR);
   assign end_cyc    = in_cycle & (is_rd_cyc ? io_read_n : io_write_n);

   assign rx_pop  = end_cyc & is_rd_cyc & (cyc_off == OFF_DATA)
                  & ~rd_empty_q;
   assign tx_push = end_cyc & ~is_rd_cyc & (cyc_off == OFF_DATA);

   assign status_val = {3'b000, tc_seen, interrupt_request, err,
                        ~tx_full, ~rx_empty};

   always_comb begin
      rd_val = 8'h00;
      case (rd_off)
         OFF_DATA:    rd_val = rx_empty ? 8'hFF : rx_head;
         OFF_STATUS:  rd_val = status_val;
         OFF_CONTROL: rd_val = {3'b000, ctrl};
         default:     rd_val = 8'(rx_count);
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         prev_low            <= 1'b1;
         in_cycle            <= 1'b0;
         cyc                 <= CYC_NONE;
         cyc_off             <= OFF_DATA;
         rd_empty_q          <= 1'b0;
         wdata_q             <= 8'h00;
         wait_cnt            <= '0;
         ctrl                <= 5'h00;
         err                 <= 1'b0;
         tc_seen             <= 1'b0;
         data_bus_out        <= 8'h00;
         data_bus_out_enable <= 1'b0;
         io_channel_ready    <= 1'b1;
         interrupt_request   <= 1'b0;
      end else begin
         prev_low <= strobe_low;
         if (start) begin
            in_cycle   <= 1'b1;
            cyc        <= start_type;
            cyc_off    <= rd_off;
            rd_empty_q <= rx_empty;
            wdata_q    <= data_bus;
            if (rd_low) begin
               data_bus_out        <= rd_val;
               data_bus_out_enable <= 1'b1;
            end
            if (WAIT_CYCLES != 0) begin
               io_channel_ready <= 1'b0;
               wait_cnt         <= WW'(WAIT_CYCLES - 1);
            end
         end else begin
            if (!io_channel_ready) begin
               if (wait_cnt == '0) io_channel_ready <= 1'b1;
               else wait_cnt <= wait_cnt - WW'(1);
            end
            if (in_cycle && !end_cyc) wdata_q <= data_bus;
            if (end_cyc) begin
               in_cycle            <= 1'b0;
               cyc                 <= CYC_NONE;
               data_bus_out_enable <= 1'b0;
               if (is_rd_cyc) begin
                  if (cyc_off == OFF_DATA && rd_empty_q) err <= 1'b1;
               end else begin
                  case (cyc_off)
                     OFF_DATA: if (tx_full) err <= 1'b1;
                     OFF_STATUS: begin
                        if (wdata_q[ST_ERR]) err <= 1'b0;
                        if (wdata_q[ST_TC]) tc_seen <= 1'b0;
                     end
                     OFF_CONTROL: ctrl <= wdata_q[4:0] & CTRL_MASK;
                     default: ;
                  endcase
               end
`ifdef ISA_MAILBOX_DMA_EN
               if (is_dma_cyc && !terminal_count_n) begin
                  tc_seen         <= 1'b1;
                  ctrl[CT_DMA_EN] <= 1'b0;
               end
`endif
            end
         end
         interrupt_request <= (ctrl[CT_RX_IRQ] & ~rx_empty)
                            | (ctrl[CT_TX_IRQ] & tx_empty)
                            | (ctrl[CT_TC_IRQ] & tc_seen);
      end
   end

`ifdef ISA_MAILBOX_DMA_EN
   always_ff @(posedge clock) begin
      if (!reset_n) dma_request <= 1'b0;
      else dma_request <= ctrl[CT_DMA_EN] & ~in_cycle
         & (ctrl[CT_DMA_DIR] ? ~rx_empty : ~tx_full);
   end
   logic unused_bits;
   assign unused_bits = ^{address[19:10], tx_count, is_dma_cyc};
`else
   assign dma_request = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{address[19:10], tx_count, is_dma_cyc,
                          dma_acknowledge_n, terminal_count_n};
`endif

   assign rx_in_ready  = ~rx_full;
   assign tx_out_valid = ~tx_empty;

   isa_mailbox_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (rx_in_valid),
      .push_data (rx_in_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   isa_mailbox_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (tx_push),
      .push_data (wdata_q),
      .pop       (tx_out_ready),
      .head      (tx_out_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

endmodule

// File: tb/tb_isa_mailbox_responder.sv
// Directed bench for isa_mailbox_responder (default parameters).
// DMA steps run only when ISA_MAILBOX_DMA_EN is defined.
module tb_isa_mailbox_responder;

   localparam logic [9:0] BASE = 10'h2E0;

   logic        clock;
   logic        reset_n;
   logic [19:0] address;
   logic [7:0]  data_bus;
   logic        io_read_n, io_write_n;
   logic        address_enable_n, dma_acknowledge_n, terminal_count_n;
   logic [7:0]  data_bus_out;
   logic        data_bus_out_enable, io_channel_ready;
   logic        interrupt_request, dma_request;
   logic [7:0]  rx_in_data;
   logic        rx_in_valid, rx_in_ready;
   logic [7:0]  tx_out_data;
   logic        tx_out_valid, tx_out_ready;

   int total = 0;
   int bad = 0;

   isa_mailbox_responder dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .address             (address),
      .data_bus            (data_bus),
      .io_read_n           (io_read_n),
      .io_write_n          (io_write_n),
      .address_enable_n    (address_enable_n),
      .dma_acknowledge_n   (dma_acknowledge_n),
      .terminal_count_n    (terminal_count_n),
      .data_bus_out        (data_bus_out),
      .data_bus_out_enable (data_bus_out_enable),
      .io_channel_ready    (io_channel_ready),
      .interrupt_request   (interrupt_request),
      .dma_request         (dma_request),
      .rx_in_data          (rx_in_data),
      .rx_in_valid         (rx_in_valid),
      .rx_in_ready         (rx_in_ready),
      .tx_out_data         (tx_out_data),
      .tx_out_valid        (tx_out_valid),
      .tx_out_ready        (tx_out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic host_read(input logic [1:0] off, output logic [7:0] d);
      @(negedge clock);
      address = 20'(BASE) | 20'(off);
      address_enable_n = 1'b0;
      io_read_n = 1'b0;
      repeat (3) @(negedge clock);
      d = data_bus_out;
      io_read_n = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic host_write(input logic [1:0] off, input logic [7:0] d);
      @(negedge clock);
      address = 20'(BASE) | 20'(off);
      address_enable_n = 1'b0;
      data_bus = d;
      io_write_n = 1'b0;
      repeat (3) @(negedge clock);
      io_write_n = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic rx_push(input logic [7:0] b);
      @(negedge clock);
      rx_in_data = b;
      rx_in_valid = 1'b1;
      @(negedge clock);
      rx_in_valid = 1'b0;
   endtask

   task automatic dma_read(input logic tc, output logic [7:0] d);
      @(negedge clock);
      address = 20'h00000;
      address_enable_n = 1'b1;
      dma_acknowledge_n = 1'b0;
      terminal_count_n = ~tc;
      io_read_n = 1'b0;
      repeat (3) @(negedge clock);
      d = data_bus_out;
      io_read_n = 1'b1;
      @(negedge clock);
      dma_acknowledge_n = 1'b1;
      terminal_count_n = 1'b1;
      address_enable_n = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      logic [7:0] rd;
      reset_n = 1'b0;
      address = 20'h0;
      data_bus = 8'h00;
      io_read_n = 1'b1;
      io_write_n = 1'b1;
      address_enable_n = 1'b0;
      dma_acknowledge_n = 1'b1;
      terminal_count_n = 1'b1;
      rx_in_data = 8'h00;
      rx_in_valid = 1'b0;
      tx_out_ready = 1'b0;
      repeat (3) @(negedge clock);

      chk("rst_ready", io_channel_ready, 1);
      chk("rst_irq", interrupt_request, 0);
      chk("rst_dreq", dma_request, 0);
      chk("rst_dout", data_bus_out, 8'h00);
      chk("rst_oe", data_bus_out_enable, 0);
      chk("rst_txv", tx_out_valid, 0);
      chk("rst_rxr", rx_in_ready, 1);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // STATUS read with wait-state timing
      address = 20'(BASE) | 20'h1;
      io_read_n = 1'b0;
      @(negedge clock);
      chk("ws_k1", io_channel_ready, 0);
      chk("oe_k1", data_bus_out_enable, 1);
      chk("st_reset", data_bus_out, 8'h02);
      @(negedge clock);
      chk("ws_k2", io_channel_ready, 0);
      @(negedge clock);
      chk("ws_k3", io_channel_ready, 1);
      chk("st_hold", data_bus_out, 8'h02);
      io_read_n = 1'b1;
      repeat (2) @(negedge clock);
      chk("oe_off", data_bus_out_enable, 0);

      // RX path, empty read, ERR clear
      rx_push(8'hA5);
      rx_push(8'h5A);
      host_read(2'd3, rd);
      chk("rxcount", rd, 8'h02);
      host_read(2'd0, rd);
      chk("rx0", rd, 8'hA5);
      host_read(2'd0, rd);
      chk("rx1", rd, 8'h5A);
      host_read(2'd0, rd);
      chk("rx_empty", rd, 8'hFF);
      host_read(2'd1, rd);
      chk("st_err", rd, 8'h06);
      host_write(2'd1, 8'h04);
      host_read(2'd1, rd);
      chk("st_errclr", rd, 8'h02);

      // TX fill, overflow drop, drain
      for (int i = 0; i < 16; i++) host_write(2'd0, 8'(8'h10 + i));
      host_read(2'd1, rd);
      chk("st_txfull", rd, 8'h00);
      host_write(2'd0, 8'h77);
      host_read(2'd1, rd);
      chk("st_txovf", rd, 8'h04);
      for (int i = 0; i < 16; i++) begin
         chk("tx_valid", tx_out_valid, 1);
         chk("tx_data", tx_out_data, 8'(8'h10 + i));
         tx_out_ready = 1'b1;
         @(negedge clock);
         tx_out_ready = 1'b0;
      end
      @(negedge clock);
      chk("tx_drained", tx_out_valid, 0);
      host_write(2'd1, 8'h04);

      // RX interrupt
      host_write(2'd2, 8'h01);
      host_read(2'd2, rd);
      chk("ctrl_rb", rd, 8'h01);
      chk("irq_idle", interrupt_request, 0);
      rx_push(8'h3C);
      chk("irq_lag", interrupt_request, 0);
      @(negedge clock);
      chk("irq_set", interrupt_request, 1);
      host_read(2'd0, rd);
      chk("irq_pop", rd, 8'h3C);
      chk("irq_clr", interrupt_request, 0);
      host_write(2'd2, 8'h00);

`ifdef ISA_MAILBOX_DMA_EN
      host_write(2'd2, 8'h1C);
      rx_push(8'h11);
      rx_push(8'h22);
      rx_push(8'h33);
      @(negedge clock);
      chk("dreq_on", dma_request, 1);
      dma_read(1'b0, rd);
      chk("dma0", rd, 8'h11);
      chk("dreq_mid", dma_request, 1);
      dma_read(1'b0, rd);
      chk("dma1", rd, 8'h22);
      dma_read(1'b1, rd);
      chk("dma2", rd, 8'h33);
      chk("dreq_off", dma_request, 0);
      chk("tc_irq", interrupt_request, 1);
      host_read(2'd2, rd);
      chk("ctrl_tc", rd, 8'h18);
      host_read(2'd1, rd);
      chk("st_tc", rd, 8'h1A);
      host_write(2'd1, 8'h10);
      host_write(2'd2, 8'h00);
      host_read(2'd1, rd);
      chk("st_tcclr", rd, 8'h02);
`else
      host_write(2'd2, 8'h1F);
      host_read(2'd2, rd);
      chk("ctrl_mask", rd, 8'h03);
      chk("dreq_tied", dma_request, 0);
      host_write(2'd2, 8'h00);
`endif

      // Strobe held low across reset release
      host_write(2'd2, 8'h03);
      host_read(2'd2, rd);
      chk("ctrl_pre", rd, 8'h03);
      @(negedge clock);
      address = 20'(BASE);
      data_bus = 8'h99;
      io_write_n = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      io_write_n = 1'b1;
      repeat (2) @(negedge clock);
      chk("held_txv", tx_out_valid, 0);
      chk("held_ready", io_channel_ready, 1);
      host_read(2'd2, rd);
      chk("held_ctrl", rd, 8'h00);
      host_read(2'd1, rd);
      chk("held_st", rd, 8'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/isa_mailbox_responder.md
# isa_mailbox_responder

ISA-side I/O responder for the KFPC-XT bus: the slave end of the I/O and DMA cycles the chipset initiates. It decodes a 4-port I/O window and moves bytes between the host bus and a local backend through two FIFOs. It inserts wait states via `io_channel_ready` and raises `interrupt_request` and `dma_request` toward the chipset's PIC and 8237 inputs.

## Interface
Parameters:
- BASE_ADDR, 10'h2E0, I/O base; decode is `address[9:2] == BASE_ADDR[9:2]`.
- FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2.
- WAIT_CYCLES, 2, wait-state clocks per decoded access; 0 means never wait.

Ports (one clock `clock`; reset `reset_n` is synchronous, active-low):
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- address  in  20  bus address from chipset
- data_bus  in  8  bus write data
- io_read_n  in  1  I/O read strobe
- io_write_n  in  1  I/O write strobe
- address_enable_n  in  1  AEN; high = DMA owns bus, address decode disabled
- dma_acknowledge_n  in  1  DACK for this card's channel
- terminal_count_n  in  1  8237 TC
- data_bus_out  out  8  read data
- data_bus_out_enable  out  1  drive request toward chipset bus mux
- io_channel_ready  out  1  low = wait state
- interrupt_request  out  1  level IRQ
- dma_request  out  1  DREQ
- rx_in_data / rx_in_valid / rx_in_ready  in/in/out  8/1/1  backend→host stream
- tx_out_data / tx_out_valid / tx_out_ready  out/out/in  8/1/1  host→backend stream

## Operation
- **Register map** (offset = `address[1:0]`):
  - 0 DATA: read pops the RX head; read while empty returns 8'hFF and sets ERR. Write pushes TX; write while full is dropped and sets ERR.
  - 1 STATUS:
    - Read bits: [0] rx_not_empty, [1] tx_not_full, [2] ERR (sticky), [3] irq pending, [4] TC_SEEN (sticky).
    - Write: 1 to bit 2 or bit 4 clears that bit.
  - 2 CONTROL, r/w: [0] rx_irq_en, [1] tx_empty_irq_en, [2] dma_en, [3] dma_dir (0 = DMA writes card/TX, 1 = DMA reads card/RX), [4] tc_irq_en. Reset value 0.
  - 3 RXCOUNT, read-only: RX occupancy, zero-extended.
- **Cycle types:**
  - Address cycle: strobe low, `address_enable_n`=0, decode hit.
  - DMA cycle: strobe low, `dma_acknowledge_n`=0, `address_enable_n`=1, CONTROL.dma_en=1; acts on DATA regardless of address.
- **Per-cycle state:**
  - A strobe sampled low after sampled high starts a cycle: set in_cycle, latch offset and type.
  - The strobe sampled high with in_cycle set ends the cycle. Writes commit `data_bus` captured on the last low sample. RX pop happens then. Clear in_cycle.
  - Strobe rises without in_cycle: no action. Both strobes low: ignore, no cycle starts.
- **TC:** `terminal_count_n` low during a DMA cycle's end sample sets TC_SEEN and clears dma_en.
- **interrupt_request** = (rx_irq_en & rx_not_empty) | (tx_empty_irq_en & tx_empty) | (tc_irq_en & TC_SEEN). Registered.
- **dma_request** = dma_en & (dir ? rx_not_empty : tx_not_full) & ~in_cycle. Registered.
- **Backend handshakes:**
  - `rx_in_ready` = RX not full; a push happens when valid & ready.
  - `tx_out_valid` = TX not empty; a pop happens when valid & ready.
  - A same-clock push and pop on one FIFO are both honoured, and the count is unchanged.

## Timing
- Start detected at clock k (first low sample). `io_channel_ready` is low for clocks k+1 … k+WAIT_CYCLES, then high.
- Reads: `data_bus_out` and `data_bus_out_enable`=1 from k+1 until the clock after the strobe's first high sample. Data is the value at k, held stable through the cycle.
- FIFO/register updates are visible one clock after the end sample.
- IRQ/DREQ lag their causes by 1 clock.
- **Reset values:**
  - `io_channel_ready`=1, `interrupt_request`=0, `dma_request`=0, `data_bus_out`=0, `data_bus_out_enable`=0, `tx_out_valid`=0, `rx_in_ready`=1.
  - FIFOs empty, sticky bits 0, in_cycle=0.
  - Strobe history resets to "low", so a strobe held low across reset release starts no cycle.
- Reset asserted mid-cycle aborts the cycle; no commit, no pop.

## Configuration
- `ISA_MAILBOX_DMA_EN` defined: DMA cycles, DREQ and TC handling as above.
- Undefined:
  - `dma_request` tied 0, and `dma_acknowledge_n`/`terminal_count_n` ignored.
  - CONTROL bits 2, 3 and 4 read 0 and writes are ignored; TC_SEEN reads 0.

## Structure
- Package `isa_mailbox_pkg`: register offset constants, STATUS/CONTROL bit-index constants, cycle-type enum (NONE/IO_RD/IO_WR/DMA_RD/DMA_WR).
- Sub-module `isa_mailbox_fifo`: synchronous FIFO (depth param, push/pop, full/empty/count, show-ahead head), instantiated for RX and TX.

## Test plan
- Reset, then read BASE+1 → 8'h02; `io_channel_ready` low exactly 2 clocks after strobe detect.
- Backend pushes 8'hA5, 8'h5A; read BASE+3 → 8'h02. Read BASE+0 twice → A5, 5A. A third read → FF with STATUS bit2=1; writing 8'h04 to BASE+1 clears it.
- Fill TX with 16 writes, then a 17th write of 8'h77 → dropped, ERR=1; backend drains 16 bytes in order with no 8'h77.
- CONTROL=8'h01 with RX empty: IRQ 0. Backend push → IRQ 1 one clock later; host pop → IRQ 0.
- (DMA_EN) CONTROL=8'h1C with 3 RX bytes; three DACK reads, TC on the third → bytes returned in order, DREQ low, dma_en=0, TC_SEEN=1, IRQ=1.
- Strobe held low through reset release, then raised → no FIFO or register change.
